// File: rtl/myproject_mac_pkg.sv
// Shared encodings and the saturating resize helper used by the MAC pipeline.
package myproject_mac_pkg;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_ACC = 1'b1
    } macMode_e;

    typedef enum int {
        SAT_WRAP  = 0,
        SAT_CLAMP = 1
    } satMode_e;

    localparam int CALC_WIDTH = 64;

    // Clamp a wide signed value into the signed range of a narrower width.
    function automatic logic signed [CALC_WIDTH-1:0] satResize(
        input logic signed [CALC_WIDTH-1:0] value,
        input int                           width
    );
        logic signed [CALC_WIDTH-1:0] maxVal;
        logic signed [CALC_WIDTH-1:0] minVal;
        maxVal = (64'sd1 <<< (width - 1)) - 64'sd1;
        minVal = -(64'sd1 <<< (width - 1));
        if (value > maxVal) return maxVal;
        if (value < minVal) return minVal;
        return value;
    endfunction

endpackage

// File: rtl/myproject_mac_pipe_mul.sv
// Signed-by-unsigned multiplier with NUM_STAGE clock-enabled pipeline registers.
module myproject_mul_pipe #(
    parameter int NUM_STAGE = 2,
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 15,
    parameter int P_WIDTH   = A_WIDTH + B_WIDTH + 1
) (
    input  logic                      i_clk,
    input  logic                      i_ce,
    input  logic signed [A_WIDTH-1:0] i_a,
    input  logic        [B_WIDTH-1:0] i_b,
    output logic signed [P_WIDTH-1:0] o_p
);

    logic signed [P_WIDTH-1:0] w_aExt;
    logic signed [P_WIDTH-1:0] w_bExt;
    logic signed [P_WIDTH-1:0] w_product;
    logic signed [P_WIDTH-1:0] r_stage [NUM_STAGE];

    // Both operands widened to the full product width so nothing is truncated.
    assign w_aExt    = {{(B_WIDTH + 1){i_a[A_WIDTH-1]}}, i_a};
    assign w_bExt    = {{(A_WIDTH + 1){1'b0}}, i_b};
    assign w_product = w_aExt * w_bExt;

    always_ff @(posedge i_clk) begin
        if (i_ce) begin
            r_stage[0] <= w_product;
            for (int i = 1; i < NUM_STAGE; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_p = r_stage[NUM_STAGE-1];

endmodule

// File: rtl/myproject_mac_pipe.sv
// Pipelined multiply / multiply-accumulate unit; ID is an instance tag only.
module myproject_mac_pipe
    import myproject_mac_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 15,
    parameter int dout_WIDTH = 26,
    parameter int ACC_WIDTH  = 34,
    parameter int SAT_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_mode,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [dout_WIDTH-1:0] dout
);

    localparam int PROD_WIDTH = din0_WIDTH + din1_WIDTH + 1;

    logic signed [PROD_WIDTH-1:0] w_product;
    logic                         r_sbValid [NUM_STAGE];
    macMode_e                     r_sbMode  [NUM_STAGE];
    logic                         r_sbFirst [NUM_STAGE];
    logic                         r_sbLast  [NUM_STAGE];
    logic                         w_beatValid;
    macMode_e                     w_beatMode;
    logic                         w_beatFirst;
    logic                         w_beatLast;

    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic        [dout_WIDTH-1:0] r_dout;
    logic                         r_outValid;

    logic signed [CALC_WIDTH-1:0] w_accBase;
    logic signed [CALC_WIDTH-1:0] w_sum;
    logic signed [CALC_WIDTH-1:0] w_sumClamped;
    logic signed [ACC_WIDTH-1:0]  w_newAcc;
    logic signed [CALC_WIDTH-1:0] w_outSrc;
    logic signed [CALC_WIDTH-1:0] w_outClamped;
    logic        [dout_WIDTH-1:0] w_doutNext;

    myproject_mul_pipe #(
        .NUM_STAGE (NUM_STAGE),
        .A_WIDTH   (din0_WIDTH),
        .B_WIDTH   (din1_WIDTH)
    ) u_mul (
        .i_clk (clk),
        .i_ce  (ce),
        .i_a   (din0),
        .i_b   (din1),
        .o_p   (w_product)
    );

    // Only the valid bits need a reset; the other sideband bits are qualified by them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                r_sbValid[i] <= 1'b0;
            end
        end else if (ce) begin
            r_sbValid[0] <= in_valid;
            for (int i = 1; i < NUM_STAGE; i++) begin
                r_sbValid[i] <= r_sbValid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            r_sbMode[0]  <= macMode_e'(in_mode);
            r_sbFirst[0] <= in_first;
            r_sbLast[0]  <= in_last;
            for (int i = 1; i < NUM_STAGE; i++) begin
                r_sbMode[i]  <= r_sbMode[i-1];
                r_sbFirst[i] <= r_sbFirst[i-1];
                r_sbLast[i]  <= r_sbLast[i-1];
            end
        end
    end

    assign w_beatValid = r_sbValid[NUM_STAGE-1];
    assign w_beatMode  = r_sbMode[NUM_STAGE-1];
    assign w_beatFirst = r_sbFirst[NUM_STAGE-1];
    assign w_beatLast  = r_sbLast[NUM_STAGE-1];

    // A first beat restarts from zero, silently dropping any unfinished run.
    assign w_accBase    = w_beatFirst ? 64'sd0 : CALC_WIDTH'(r_acc);
    assign w_sum        = w_accBase + CALC_WIDTH'(w_product);
    assign w_sumClamped = satResize(w_sum, ACC_WIDTH);
    assign w_newAcc     = (SAT_MODE == SAT_CLAMP) ? w_sumClamped[ACC_WIDTH-1:0] : w_sum[ACC_WIDTH-1:0];

    assign w_outSrc     = (w_beatMode == MODE_ACC) ? CALC_WIDTH'(w_newAcc) : CALC_WIDTH'(w_product);
    assign w_outClamped = satResize(w_outSrc, dout_WIDTH);
    assign w_doutNext   = (SAT_MODE == SAT_CLAMP) ? w_outClamped[dout_WIDTH-1:0] : w_outSrc[dout_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_dout     <= '0;
            r_acc      <= '0;
        end else if (ce) begin
            r_outValid <= 1'b0;
            if (w_beatValid) begin
                if (w_beatMode == MODE_ACC) begin
                    r_acc <= w_newAcc;
                    if (w_beatLast) begin
                        r_outValid <= 1'b1;
                        r_dout     <= w_doutNext;
                    end
                end else begin
                    r_outValid <= 1'b1;
                    r_dout     <= w_doutNext;
                end
            end
        end
    end

    assign out_valid = r_outValid;
    assign dout      = r_dout;

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Scoreboard bench driving a wrapping and a saturating MAC instance with identical stimulus.
module tb_myproject_mac_pipe;

    localparam int NUM_STAGE = 2;
    localparam int D0W       = 16;
    localparam int D1W       = 15;
    localparam int DOW       = 26;
    localparam int ACCW      = 34;

    localparam int KIND_NONE   = 0;
    localparam int KIND_ENABLE = 1;
    localparam int KIND_HOLD   = 2;
    localparam int KIND_RESET  = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           ce = 1'b0;
    logic           inValid = 1'b0;
    logic           inMode = 1'b0;
    logic           inFirst = 1'b0;
    logic           inLast = 1'b0;
    logic [D0W-1:0] din0 = '0;
    logic [D1W-1:0] din1 = '0;
    logic           outValidW;
    logic [DOW-1:0] doutW;
    logic           outValidS;
    logic [DOW-1:0] doutS;

    typedef struct {
        longint valW;
        longint valS;
        int     dueEdge;
    } expect_t;

    expect_t        expQ [$];
    longint         accW = 0;
    longint         accS = 0;
    int             ceEdges = 0;
    int             edgeKind = KIND_NONE;
    int             nVectors = 0;
    int             nMiss = 0;
    logic           prevOvW = 1'b0;
    logic           prevOvS = 1'b0;
    logic [DOW-1:0] prevDoutW = '0;
    logic [DOW-1:0] prevDoutS = '0;

    always #5 clk = ~clk;

    myproject_mac_pipe #(.ID(1), .NUM_STAGE(NUM_STAGE), .din0_WIDTH(D0W), .din1_WIDTH(D1W),
                         .dout_WIDTH(DOW), .ACC_WIDTH(ACCW), .SAT_MODE(0)) dutWrap (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid), .in_mode(inMode),
        .in_first(inFirst), .in_last(inLast), .din0(din0), .din1(din1),
        .out_valid(outValidW), .dout(doutW)
    );

    myproject_mac_pipe #(.ID(2), .NUM_STAGE(NUM_STAGE), .din0_WIDTH(D0W), .din1_WIDTH(D1W),
                         .dout_WIDTH(DOW), .ACC_WIDTH(ACCW), .SAT_MODE(1)) dutSat (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid), .in_mode(inMode),
        .in_first(inFirst), .in_last(inLast), .din0(din0), .din1(din1),
        .out_valid(outValidS), .dout(doutS)
    );

    // Two's-complement wrap into a signed field of the given width.
    function automatic longint wrapTo(input longint v, input int w);
        longint span;
        longint m;
        span = longint'(1) << w;
        m = v % span;
        if (m < 0) m = m + span;
        if (m >= span / 2) m = m - span;
        return m;
    endfunction

    function automatic longint clampTo(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic modelBeat(input logic m, input logic f, input logic l, input int d0, input int d1);
        longint  p;
        expect_t e;
        p = longint'(d0) * longint'(d1);
        e.dueEdge = ceEdges + NUM_STAGE;
        if (!m) begin
            e.valW = wrapTo(p, DOW);
            e.valS = clampTo(p, DOW);
            expQ.push_back(e);
        end else begin
            accW = wrapTo((f ? 64'sd0 : accW) + p, ACCW);
            accS = clampTo((f ? 64'sd0 : accS) + p, ACCW);
            if (l) begin
                e.valW = wrapTo(accW, DOW);
                e.valS = clampTo(accS, DOW);
                expQ.push_back(e);
            end
        end
    endtask

    // One clock of stimulus; the model is updated at the edge that samples it.
    task automatic applyStimulus(input logic v, input logic m, input logic f, input logic l,
                                 input int d0, input int d1, input logic c, input logic r);
        inValid = v;
        inMode  = m;
        inFirst = f;
        inLast  = l;
        din0    = D0W'(d0);
        din1    = D1W'(d1);
        ce      = c;
        reset   = r;
        @(posedge clk);
        if (r) begin
            expQ.delete();
            accW = 0;
            accS = 0;
            edgeKind = KIND_RESET;
        end else if (c) begin
            ceEdges++;
            edgeKind = KIND_ENABLE;
            if (v) modelBeat(m, f, l, d0, d1);
        end else begin
            edgeKind = KIND_HOLD;
        end
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic checkOutput(input string name, input string which, input logic ov, input logic [DOW-1:0] dv,
                               input logic expOv, input logic [DOW-1:0] expD);
        nVectors++;
        if (ov !== expOv || dv !== expD) begin
            nMiss++;
            $display("[TB] FAIL %s (%s) at ce-edge %0d: got out_valid=%0b dout=0x%h, expected out_valid=%0b dout=0x%h",
                     name, which, ceEdges, ov, dv, expOv, expD);
        end
    endtask

    // Monitor: decides what each instance should present after every clock edge.
    always @(negedge clk) begin
        logic           eOv;
        logic [DOW-1:0] eW;
        logic [DOW-1:0] eS;
        longint         tmp;
        string          nm;
        if (edgeKind != KIND_NONE) begin
            if (edgeKind == KIND_RESET) begin
                nm = "resetState"; eOv = 1'b0; eW = '0; eS = '0;
            end else if (edgeKind == KIND_HOLD) begin
                nm = "ceHold"; eOv = prevOvW; eW = prevDoutW; eS = prevDoutS;
            end else if (expQ.size() > 0 && expQ[0].dueEdge == ceEdges) begin
                nm = "result"; eOv = 1'b1;
                tmp = expQ[0].valW; eW = tmp[DOW-1:0];
                tmp = expQ[0].valS; eS = tmp[DOW-1:0];
                expQ.pop_front();
            end else begin
                nm = "noResult"; eOv = 1'b0; eW = prevDoutW; eS = prevDoutS;
            end
            checkOutput(nm, "wrap", outValidW, doutW, eOv, eW);
            checkOutput(nm, "sat", outValidS, doutS, eOv, eS);
            prevOvW = outValidW; prevDoutW = doutW;
            prevOvS = outValidS; prevDoutS = doutS;
        end
    end

    function automatic int randOp0();
        case ($urandom_range(0, 7))
            0:       return -32768;
            1:       return 32767;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    function automatic int randOp1();
        case ($urandom_range(0, 7))
            0:       return 32767;
            1:       return 0;
            default: return int'($urandom_range(0, 32767));
        endcase
    endfunction

    initial begin
        $display("[TB] start");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);

        // Accumulate beat with no first since reset starts from zero.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3, 4, 1'b1, 1'b0);
        idleCycles(4);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, -3, 5, 1'b1, 1'b0);
        idleCycles(4);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, -32768, 32767, 1'b1, 1'b0);
        idleCycles(4);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2, 3, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4, 5, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, -1, 10, 1'b1, 1'b0);
        idleCycles(4);

        // Clock-enable stalls both mid-pipeline and while the result is showing.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7, 9, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 11, 13, 1'b0, 1'b0);
        idleCycles(2);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 11, 13, 1'b0, 1'b0);
        idleCycles(3);

        // Reset with ce low must still flush the partial run and in-flight beats.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1, 1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2, 2, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 9, 9, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 7, 1, 1'b1, 1'b0);
        idleCycles(4);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5, 5, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3, 2, 1'b1, 1'b0);
        idleCycles(4);

        // Long negative run overflows the accumulator width.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, -32768, 32767, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, -32768, 32767, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, -32768, 32767, 1'b1, 1'b0);
        idleCycles(4);

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          randOp0(), randOp1(), $urandom_range(0, 9) != 0,
                          $urandom_range(0, 99) == 0);
        end
        idleCycles(6);

        nVectors++;
        if (expQ.size() != 0) begin
            nMiss++;
            $display("[TB] FAIL drain: got %0d results still outstanding, expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule
